iterative_alu: RTL and testbench

Parametrised successor to the single-cycle ALU in the EX stage: executes the same twelve combinational operations in one cycle and adds iterative signed/unsigned multiply and divide with HI/LO result registers. A start/busy/done handshake lets the pipeline stall while a multi-cycle operation runs. It drives the EX-stage result, the HI/LO registers read by mfhi/mflo, and an overflow flag for add/sub traps.

---
 rtl/iterative_alu.sv | 156 +++++++++++++++
 tb/tb_iterative_alu.sv | 139 +++++++++++++
 2 files changed

// File: rtl/iterative_alu.sv
// iterative_alu: single-cycle ALU ops plus iterative mult/div into HI/LO with start/busy/done handshake
module iterative_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             div_zero
);
  localparam int CW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     p_q, p_d;
  logic [WIDTH-1:0]       m_q, m_d;
  logic [3:0]             op_q, op_d;
  logic                   neg_q, neg_d, sa_q, sa_d, dz_q, dz_d;
  logic [WIDTH-1:0]       res_q, res_d, hi_q, hi_d, lo_q, lo_d;
  logic                   ovf_q, ovf_d, divz_q, divz_d, done_q, done_d;
  logic [SHAMT_W-1:0]     sh;
  logic [WIDTH-1:0]       sum, dif, f, mag_a, mag_b, quo, rem;
  logic                   ovf_add, ovf_sub, sgn, sign_a, sign_b;
  logic [WIDTH:0]         msum, rsh, rdiff;
  logic [2*WIDTH-1:0]     pm, pd, prod;
  assign sh      = inputA[SHAMT_W-1:0];
  assign sum     = inputA + inputB;
  assign dif     = inputA - inputB;
  assign ovf_add = (inputA[MSB] == inputB[MSB]) && (sum[MSB] != inputA[MSB]);
  assign ovf_sub = (inputA[MSB] != inputB[MSB]) && (dif[MSB] != inputA[MSB]);
  assign f = (operation == 4'd0 || operation == 4'd1) ? sum :
             (operation == 4'd2 || operation == 4'd3) ? dif :
             (operation == 4'd4)  ? (inputA & inputB) :
             (operation == 4'd5)  ? (inputA | inputB) :
             (operation == 4'd6)  ? (inputA ^ inputB) :
             (operation == 4'd7)  ? ~(inputA | inputB) :
             (operation == 4'd8)  ? (inputB << sh) :
             (operation == 4'd9)  ? (inputB >> sh) :
             (operation == 4'd10) ? WIDTH'($signed(inputB) >>> sh) :
             {inputB[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
  // signed variants have operation[0]=0 (MULT, DIV)
  assign sgn    = ~operation[0];
  assign sign_a = sgn & inputA[MSB];
  assign sign_b = sgn & inputB[MSB];
  assign mag_a  = sign_a ? -inputA : inputA;
  assign mag_b  = sign_b ? -inputB : inputB;
  // shift-add step: add multiplicand into the upper half, shift the pair right
  assign msum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? m_q : {WIDTH{1'b0}})};
  assign pm    = {msum, p_q[WIDTH-1:1]};
  // restoring step: upper half is the partial remainder, lower half shifts in quotient bits
  assign rsh   = p_q[2*WIDTH-1:WIDTH-1];
  assign rdiff = rsh - {1'b0, m_q};
  assign pd    = rdiff[WIDTH] ? {rsh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                              : {rdiff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
  assign prod  = neg_q ? -p_q : p_q;
  assign quo   = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
  assign rem   = sa_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    m_d     = m_q;
    op_d    = op_q;
    neg_d   = neg_q;
    sa_d    = sa_q;
    dz_d    = dz_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ovf_d   = ovf_q;
    divz_d  = divz_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        if (operation[3:2] == 2'b11) begin
          op_d    = operation;
          neg_d   = sign_a ^ sign_b;
          sa_d    = sign_a;
          dz_d    = operation[1] && (inputB == '0);
          // a zero divisor keeps the raw dividend so FIX can return it in hi
          p_d     = {{WIDTH{1'b0}}, ((operation[1] && inputB == '0) ? inputA : mag_a)};
          m_d     = mag_b;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          res_d  = f;
          ovf_d  = (operation == 4'd0) ? ovf_add : (operation == 4'd2) ? ovf_sub : 1'b0;
          done_d = 1'b1;
        end
      end
      RUN: begin
        p_d     = op_q[1] ? (dz_q ? p_q : pd) : pm;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : RUN;
      end
      FIX: begin
        hi_d    = !op_q[1] ? prod[2*WIDTH-1:WIDTH] : dz_q ? p_q[WIDTH-1:0] : rem;
        lo_d    = !op_q[1] ? prod[WIDTH-1:0] : dz_q ? {WIDTH{1'b1}} : quo;
        divz_d  = op_q[1] ? dz_q : divz_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      m_q     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      dz_q    <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ovf_q   <= 1'b0;
      divz_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      m_q     <= m_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      sa_q    <= sa_d;
      dz_q    <= dz_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ovf_q   <= ovf_d;
      divz_q  <= divz_d;
      done_q  <= done_d;
    end
  end
  assign result   = res_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign div_zero = divz_q;
endmodule

// File: tb/tb_iterative_alu.sv
// tb_iterative_alu: directed scenario tasks for iterative_alu with hand-computed expectations
module tb_iterative_alu;
  logic        clk, rst, start, busy, done, overflow, div_zero;
  logic [3:0]  operation;
  logic [31:0] inputA, inputB, result, hi, lo;
  int          vec, errs, n;
  iterative_alu dut (
    .clk(clk), .rst(rst), .start(start), .operation(operation),
    .inputA(inputA), .inputB(inputB), .result(result), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .overflow(overflow), .div_zero(div_zero)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // called at a negedge; returns at the negedge just after the accepting edge
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; operation = op; inputA = a; inputB = b;
    @(negedge clk);
    start = 1'b0; operation = 4'd0; inputA = 32'hDEAD_BEEF; inputB = 32'h1234_5678;
  endtask
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vec++; if ({result, hi, lo} !== 96'd0) begin errs++; $display("FAIL reset_data got %h %h %h want 0", result, hi, lo); end
    vec++; if ({busy, done, overflow, div_zero} !== 4'b0) begin errs++; $display("FAIL reset_flags got %b want 0000", {busy, done, overflow, div_zero}); end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_add;
    issue(4'd0, 32'h7FFF_FFFF, 32'd1);
    vec++; if (result !== 32'h8000_0000) begin errs++; $display("FAIL add_result got %h want 80000000", result); end
    vec++; if ({overflow, done, busy} !== 3'b110) begin errs++; $display("FAIL add_flags got %b want 110", {overflow, done, busy}); end
    @(negedge clk);
    vec++; if (done !== 1'b0) begin errs++; $display("FAIL add_done_pulse got %b want 0", done); end
    issue(4'd1, 32'h7FFF_FFFF, 32'd1);
    vec++; if ({result, overflow} !== {32'h8000_0000, 1'b0}) begin errs++; $display("FAIL addu got %h ovf %b want 80000000 ovf 0", result, overflow); end
    issue(4'd2, 32'h8000_0000, 32'd1);
    vec++; if ({result, overflow} !== {32'h7FFF_FFFF, 1'b1}) begin errs++; $display("FAIL sub_ovf got %h ovf %b want 7fffffff ovf 1", result, overflow); end
    issue(4'd7, 32'h0F0F_0000, 32'h0000_00F0);
    vec++; if ({result, overflow} !== {32'hF0F0_FF0F, 1'b0}) begin errs++; $display("FAIL nor got %h ovf %b want f0f0ff0f ovf 0", result, overflow); end
  endtask
  task automatic test_shift;
    issue(4'd10, 32'h0000_0024, 32'hF000_0000);
    vec++; if (result !== 32'hFF00_0000) begin errs++; $display("FAIL sra got %h want ff000000", result); end
    issue(4'd9, 32'h0000_0024, 32'hF000_0000);
    vec++; if (result !== 32'h0F00_0000) begin errs++; $display("FAIL srl got %h want 0f000000", result); end
    issue(4'd8, 32'h0000_0021, 32'h0000_0003);
    vec++; if (result !== 32'h0000_0006) begin errs++; $display("FAIL sll got %h want 00000006", result); end
    issue(4'd11, 32'd0, 32'h1234_ABCD);
    vec++; if (result !== 32'hABCD_0000) begin errs++; $display("FAIL lui got %h want abcd0000", result); end
  endtask
  task automatic test_mult;
    issue(4'd12, 32'hFFFF_FFFD, 32'd7);
    vec++; if ({busy, done} !== 2'b10) begin errs++; $display("FAIL mult_busy got %b want 10", {busy, done}); end
    wait_done(n);
    vec++; if (n !== 33) begin errs++; $display("FAIL mult_latency got %0d want 33", n + 1); end
    vec++; if ({hi, lo, busy} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0}) begin errs++; $display("FAIL mult got %h %h busy %b want ffffffff ffffffeb 0", hi, lo, busy); end
    vec++; if (result !== 32'hABCD_0000) begin errs++; $display("FAIL mult_keeps_result got %h want abcd0000", result); end
    @(negedge clk);
    issue(4'd13, 32'hFFFF_FFFF, 32'd2);
    wait_done(n);
    vec++; if ({hi, lo} !== {32'd1, 32'hFFFF_FFFE}) begin errs++; $display("FAIL multu got %h %h want 00000001 fffffffe", hi, lo); end
    @(negedge clk);
  endtask
  task automatic test_div;
    issue(4'd14, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    vec++; if ({hi, lo, div_zero} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}) begin errs++; $display("FAIL div got %h %h dz %b want ffffffff fffffffd 0", hi, lo, div_zero); end
    @(negedge clk);
    issue(4'd15, 32'd7, 32'd0);
    wait_done(n);
    vec++; if (n !== 33) begin errs++; $display("FAIL divz_latency got %0d want 33", n + 1); end
    vec++; if ({hi, lo, div_zero} !== {32'd7, 32'hFFFF_FFFF, 1'b1}) begin errs++; $display("FAIL divu_zero got %h %h dz %b want 00000007 ffffffff 1", hi, lo, div_zero); end
    @(negedge clk);
    issue(4'd14, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    vec++; if ({hi, lo, div_zero} !== {32'd0, 32'h8000_0000, 1'b0}) begin errs++; $display("FAIL div_minneg got %h %h dz %b want 00000000 80000000 0", hi, lo, div_zero); end
    @(negedge clk);
    issue(4'd15, 32'hFFFF_FFF0, 32'd3);
    wait_done(n);
    vec++; if ({hi, lo} !== {32'd0, 32'h5555_5550}) begin errs++; $display("FAIL divu got %h %h want 00000000 55555550", hi, lo); end
    @(negedge clk);
  endtask
  task automatic test_busy_ignore;
    issue(4'd14, 32'd100, 32'd7);
    issue(4'd4, 32'hFFFF_FFFF, 32'h0000_00FF);
    wait_done(n);
    vec++; if (n !== 32) begin errs++; $display("FAIL busy_div_latency got %0d want 32", n + 2); end
    vec++; if ({hi, lo, result} !== {32'd2, 32'd14, 32'hABCD_0000}) begin errs++; $display("FAIL busy_ignore got %h %h %h want 00000002 0000000e abcd0000", hi, lo, result); end
    @(negedge clk);
    vec++; if ({done, busy} !== 2'b00) begin errs++; $display("FAIL busy_no_queue got %b want 00", {done, busy}); end
  endtask
  task automatic test_back_to_back;
    issue(4'd12, 32'd5, 32'd6);
    wait_done(n);
    vec++; if ({hi, lo} !== {32'd0, 32'd30}) begin errs++; $display("FAIL b2b_first got %h %h want 0 1e", hi, lo); end
    issue(4'd13, 32'h0001_0000, 32'h0001_0000);
    vec++; if ({busy, done} !== 2'b10) begin errs++; $display("FAIL b2b_accept got %b want 10", {busy, done}); end
    wait_done(n);
    vec++; if ({n, hi, lo} !== {32'd33, 32'd1, 32'd0}) begin errs++; $display("FAIL b2b_second got n=%0d %h %h want 33 1 0", n, hi, lo); end
    @(negedge clk);
  endtask
  task automatic test_reset_mid;
    logic seen;
    issue(4'd12, 32'd123, 32'd456);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vec++; if ({busy, done, hi, lo, result} !== 98'd0) begin errs++; $display("FAIL mid_reset got busy %b done %b %h %h %h want all 0", busy, done, hi, lo, result); end
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen |= done;
    end
    vec++; if (seen !== 1'b0) begin errs++; $display("FAIL mid_reset_done got %b want 0", seen); end
    issue(4'd0, 32'd1, 32'd2);
    vec++; if ({result, done, overflow} !== {32'd3, 1'b1, 1'b0}) begin errs++; $display("FAIL post_reset_add got %h done %b ovf %b want 3 1 0", result, done, overflow); end
  endtask
  initial begin
    vec = 0; errs = 0; rst = 1'b1; start = 1'b0; operation = 4'd0; inputA = '0; inputB = '0;
    test_reset;
    test_add;
    test_shift;
    test_mult;
    test_div;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
